// File: rtl/uart_host_bridge.sv
// uart_host_bridge: sits between the controller and a byte-level UART.
// The host pushes bytes into a TX FIFO and pops received bytes from an RX FIFO.
// A small FSM feeds the UART one byte per frame. The baud divisor is only
// updated between frames.
module uart_host_bridge #(
    parameter int          DEPTH        = 16,
    parameter logic [15:0] DEFAULT_BAUD = 16'd5208
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_level,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   tx_overflow,
    output logic                   rx_overrun,
    input  logic                   clr_flags,
    input  logic                   baud_wr,
    input  logic [15:0]            baud_data,
    output logic                   busy,
    output logic [15:0]            Baudios,
    output logic                   TxInit,
    output logic [7:0]             TxData,
    input  logic                   TxDone,
    input  logic [7:0]             RxData,
    input  logic                   RxAvailable
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] ZERO_LEVEL = {LW{1'b0}};

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxStart = 2'd1,
        TxWait  = 2'd2
    } txState_t;

    txState_t       txState;

    logic [7:0]     txMem [0:DEPTH-1];
    logic [AW-1:0]  txWrPtr;
    logic [AW-1:0]  txRdPtr;

    logic [7:0]     rxMem [0:DEPTH-1];
    logic [AW-1:0]  rxWrPtr;
    logic [AW-1:0]  rxRdPtr;

    logic           txDoneSync;
    logic           txDonePrev;
    logic           rxAvailSync;
    logic           rxAvailPrev;
    logic [7:0]     rxDataSync;

    logic [15:0]    pendingBaud;
    logic           pendingValid;

    logic           txPush;
    logic           txPop;
    logic           rxPush;
    logic           rxPop;
    logic           txDoneEvent;
    logic           rxEvent;
    logic           overflowEvent;
    logic           overrunEvent;
    logic           baudApply;

    // Status outputs decoded purely from registered state.
    assign tx_full  = (tx_level == FULL_LEVEL);
    assign rx_empty = (rx_level == ZERO_LEVEL);
    assign busy     = (txState != TxIdle) || (tx_level != ZERO_LEVEL);

    // Event detection and FIFO push/pop qualification.
    always_comb begin
        txDoneEvent   = txDoneSync & ~txDonePrev;
        rxEvent       = rxAvailSync & ~rxAvailPrev;
        // Full is judged on the registered level; a same-cycle pop does not free a slot.
        txPush        = wr_en && (tx_level != FULL_LEVEL);
        overflowEvent = wr_en && (tx_level == FULL_LEVEL);
        txPop         = (txState == TxIdle) && (tx_level != ZERO_LEVEL);
        rxPop         = rd_en && (rx_level != ZERO_LEVEL);
        // A simultaneous pop makes room for an incoming byte even when full.
        rxPush        = rxEvent && ((rx_level != FULL_LEVEL) || rxPop);
        overrunEvent  = rxEvent && !rxPush;
        // The divisor only moves when no frame is running or about to start.
        baudApply     = pendingValid && (txState == TxIdle) && !txPop;
    end

    // Register the UART status inputs once, and keep their previous values for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            txDoneSync  <= 1'b0;
            txDonePrev  <= 1'b0;
            rxAvailSync <= 1'b0;
            rxAvailPrev <= 1'b0;
            rxDataSync  <= 8'h00;
        end else begin
            txDoneSync  <= TxDone;
            txDonePrev  <= txDoneSync;
            rxAvailSync <= RxAvailable;
            rxAvailPrev <= rxAvailSync;
            rxDataSync  <= RxData;
        end
    end

    // TX FIFO storage; the contents are don't-care while the level is zero.
    always_ff @(posedge Clock) begin
        if (txPush) begin
            txMem[txWrPtr] <= wr_data;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            txWrPtr  <= {AW{1'b0}};
            txRdPtr  <= {AW{1'b0}};
            tx_level <= ZERO_LEVEL;
        end else begin
            if (txPush) begin
                txWrPtr <= txWrPtr + 1'b1;
            end
            if (txPop) begin
                txRdPtr <= txRdPtr + 1'b1;
            end
            case ({txPush, txPop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
        end
    end

    // TX FSM: pop a byte into TxData, pulse TxInit for one cycle, then wait for frame completion.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            txState <= TxIdle;
            TxInit  <= 1'b0;
            TxData  <= 8'h00;
        end else begin
            case (txState)
                TxIdle: begin
                    if (txPop) begin
                        TxData  <= txMem[txRdPtr];
                        TxInit  <= 1'b1;
                        txState <= TxStart;
                    end else begin
                        TxInit  <= 1'b0;
                    end
                end
                TxStart: begin
                    TxInit  <= 1'b0;
                    txState <= TxWait;
                end
                TxWait: begin
                    TxInit <= 1'b0;
                    if (txDoneEvent) begin
                        txState <= TxIdle;
                    end
                end
                default: begin
                    TxInit  <= 1'b0;
                    txState <= TxIdle;
                end
            endcase
        end
    end

    // RX FIFO storage; a write may target the slot being read when full with a pop.
    always_ff @(posedge Clock) begin
        if (rxPush) begin
            rxMem[rxWrPtr] <= rxDataSync;
        end
    end

    // RX FIFO pointers, occupancy and the registered read port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rxWrPtr  <= {AW{1'b0}};
            rxRdPtr  <= {AW{1'b0}};
            rx_level <= ZERO_LEVEL;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rxPop;
            if (rxPop) begin
                rd_data <= rxMem[rxRdPtr];
                rxRdPtr <= rxRdPtr + 1'b1;
            end
            if (rxPush) begin
                rxWrPtr <= rxWrPtr + 1'b1;
            end
            case ({rxPush, rxPop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle beats the clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (overflowEvent) begin
                tx_overflow <= 1'b1;
            end else if (clr_flags) begin
                tx_overflow <= 1'b0;
            end
            if (overrunEvent) begin
                rx_overrun <= 1'b1;
            end else if (clr_flags) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    // Baud divisor: latch requests as pending and apply them only between frames.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Baudios      <= DEFAULT_BAUD;
            pendingBaud  <= 16'h0000;
            pendingValid <= 1'b0;
        end else begin
            if (baudApply) begin
                Baudios <= pendingBaud;
            end
            if (baud_wr) begin
                pendingBaud  <= baud_data;
                pendingValid <= 1'b1;
            end else if (baudApply) begin
                pendingValid <= 1'b0;
            end
        end
    end

endmodule
